seq_add_sequencer: RTL
======================

Name: seq_add_sequencer

Overview:
- Upstream sequencer for the team's registered 4-bit ripple-carry slice.
- Accepts one wide add request (WIDTH = 4*NIBBLES), splits the operands into nibbles and issues them LSB-first to the slice. Carry is chained through the slice's registered cout.
- Reassembles the wide sum and carry-out and signals completion.
- Slice timing: inputs sampled on edge k; out/cout registered on edge k+1; valid during the cycle after edge k+1.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation (WIDTH = 4*NIBBLES; legal range 1..16).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request pulse; accepted only in IDLE
- a  input  4*NIBBLES  operand A, latched on accept
- b  input  4*NIBBLES  operand B, latched on accept
- cin  input  1  carry-in, latched on accept
- busy  output  1  high from the cycle after accept until the last CAPTURE, inclusive
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  4*NIBBLES  assembled result, held until the next accept
- cout  output  1  final carry-out, held until the next accept
- slice_in1  output  4  nibble of A to the slice
- slice_in2  output  4  nibble of B to the slice
- slice_cin  output  1  carry to the slice
- slice_out  input  4  registered sum nibble from the slice
- slice_cout  input  1  registered carry from the slice

Behaviour:
- Reset: rst synchronous, active-high; clock clk. On reset: state=IDLE, busy=0, done=0, sum=0, cout=0, slice_in1/in2/cin=0, nibble index=0, internal carry=0.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE. All registered; outputs are registered or decoded from state.
- IDLE:
  - start=1 latches a, b, cin (carry_reg<=cin), idx<=0, then goes to ISSUE.
  - start=0 stays in IDLE.
- ISSUE:
  - slice_in1=a_reg[4*idx+:4], slice_in2=b_reg[4*idx+:4], slice_cin=carry_reg. The slice samples these at the closing edge.
  - Next state: WAIT.
- WAIT: slice computes and registers; slice_* driven 0. Next state: CAPTURE.
- CAPTURE:
  - sum[4*idx+:4]<=slice_out; carry_reg<=slice_cout.
  - If idx==NIBBLES-1: cout<=slice_cout, go to DONE. Else idx<=idx+1, go to ISSUE.
- DONE: done=1 for exactly one cycle, busy=0. Next state: IDLE unconditionally.
- Slice drive outside ISSUE: slice_in1/in2/cin are 0.
- Latency: 3 cycles per nibble. With start sampled at edge 0, done is high in cycle 3*NIBBLES+1 (cycle 13 for NIBBLES=4).
- Throughput: one operation per 3*NIBBLES+2 cycles.
- Handshake and boundary cases:
  - start during ISSUE/WAIT/CAPTURE/DONE is ignored; operands are not re-latched.
  - start in the cycle following DONE (IDLE) is accepted.
  - sum and cout are not cleared on accept. Partial nibbles overwrite the sum progressively, so sum is valid only while done=1 or in IDLE after done.
- Width: arithmetic is modulo 2^WIDTH. cout is the slice carry of the MSB nibble.
- Reset mid-operation: the operation is aborted immediately and no done is produced. The slice shares rst, so both return to zero in the same cycle.

Optional Feature:
- Macro: SEQ_ADD_OVF_EN.
- Enabled:
  - Extra output port ovf (1 bit), registered.
  - On the final CAPTURE, ovf <= (a_reg[MSB]==b_reg[MSB]) && (slice_out[3]!=a_reg[MSB]), i.e. two's-complement signed overflow.
  - ovf resets to 0 and is held with sum.
- Disabled: no ovf port, no related logic; all other behaviour is identical.

Test Plan:
- NIBBLES=4 throughout; bench instantiates the registered 4-bit slice.
- a=0x1234, b=0x4321, cin=0, start at edge 0 -> done=1 in cycle 13, sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 nibbles); busy high for cycles 1..12.
- a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0; slice_cin=1 only in the first ISSUE cycle.
- Accept a=0x00FF, b=0x0001; pulse start with a=0xAAAA, b=0x5555 in cycle 4 -> second request ignored, sum=0x0100, single done pulse.
- Start a=0x1111, b=0x2222; assert rst in cycle 5 -> next cycle busy=0, sum=0, cout=0, no done. Then start a=0x0F0F, b=0x0101 -> sum=0x1010, cout=0.
- SEQ_ADD_OVF_EN defined: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0xFFFF -> sum=0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/seq_add_sequencer.sv
// Purpose: sequences a 4*NIBBLES-bit add through a registered 4-bit slice, LSB nibble first, and reassembles sum/cout.
// Latency: 3 cycles per nibble; done pulses in cycle 3*NIBBLES+1 after the accept edge; one op per 3*NIBBLES+2 cycles.
// Backpressure: start is only honoured in IDLE (busy=0, done=0); requests at other times are dropped. Optional ovf port: SEQ_ADD_OVF_EN.
module seq_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic [3:0]             slice_in1,
    output logic [3:0]             slice_in2,
    output logic                   slice_cin,
    input  logic [3:0]             slice_out,
    input  logic                   slice_cout
`ifdef SEQ_ADD_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands and result viewed as arrays of nibbles so the active nibble is a plain index.
    logic [NIBBLES-1:0][3:0] a_reg;
    logic [NIBBLES-1:0][3:0] b_reg;
    logic [NIBBLES-1:0][3:0] sum_reg;
    logic                    carry_reg;
    logic [IDX_W-1:0]        idx;
    logic                    last_nib;

    assign last_nib = (idx == IDX_W'(NIBBLES - 1));
    assign sum      = sum_reg;

    // State register; reset aborts any in-flight operation without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the state-decoded outputs (busy, done, slice drive).
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        slice_in1 = 4'h0;
        slice_in2 = 4'h0;
        slice_cin = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                slice_in1 = a_reg[idx];
                slice_in2 = b_reg[idx];
                slice_cin = carry_reg;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy      = 1'b1;
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy      = 1'b1;
                state_nxt = last_nib ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: latch the request on accept, fold each returned nibble and carry into the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            cout      <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                    end
                end
                S_CAPTURE: begin
                    sum_reg[idx] <= slice_out;
                    carry_reg    <= slice_cout;
                    if (last_nib) begin
                        cout <= slice_cout;
`ifdef SEQ_ADD_OVF_EN
                        // Signed overflow: operands agree in sign but the result sign differs.
                        ovf  <= (a_reg[NIBBLES-1][3] == b_reg[NIBBLES-1][3]) &&
                                (slice_out[3] != a_reg[NIBBLES-1][3]);
`endif
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
